// File: rtl/axi_r_return_router_if.sv
// Master-side AXI R channel bundle for the return router.
// master: router drives R payload/valid, samples rready.
interface axi_r_return_router_if #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 32
);
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [ID_WIDTH-1:0]   rid;
  logic [1:0]            rresp;
  logic                  rlast;

  modport master (
    output rvalid, rdata, rid, rresp, rlast,
    input  rready
  );

  modport slave (
    input  rvalid, rdata, rid, rresp, rlast,
    output rready
  );
endinterface

// File: rtl/axi_r_return_router.sv
// Pops {slave_sel, arlen} from the read-order queue and steers that
// slave's R beats to one master port in AR issue order.
// Ports: clk, rst (async low); queue head/empty/dequeue;
// packed per-slave R inputs s_r*; master R bundle m_r; busy; len_error.
module axi_r_return_router #(
  parameter int NUM_SLAVES = 4,
  parameter int SEL_WIDTH  = 2,
  parameter int LEN_WIDTH  = 8,
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [SEL_WIDTH+LEN_WIDTH-1:0]   queue_head_data,
  input  logic                             queue_empty,
  output logic                             queue_dequeue,
  input  logic [NUM_SLAVES-1:0]            s_rvalid,
  output logic [NUM_SLAVES-1:0]            s_rready,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
  input  logic [NUM_SLAVES*ID_WIDTH-1:0]   s_rid,
  input  logic [NUM_SLAVES*2-1:0]          s_rresp,
  input  logic [NUM_SLAVES-1:0]            s_rlast,
  axi_r_return_router_if.master            m_r,
  output logic                             busy,
  output logic                             len_error
);

  typedef enum logic [1:0] {
    IDLE,
    ROUTE,
    DECERR
  } state_t;

  state_t               state;
  logic [SEL_WIDTH-1:0] sel;
  logic [LEN_WIDTH-1:0] len;
  logic [LEN_WIDTH-1:0] count;

  logic [SEL_WIDTH-1:0] head_sel;
  logic [LEN_WIDTH-1:0] head_len;
  logic                 head_ok;

  logic [NUM_SLAVES-1:0] sl_hot;
  logic                  sl_valid;
  logic                  sl_last;
  logic [DATA_WIDTH-1:0] sl_data;
  logic [ID_WIDTH-1:0]   sl_id;
  logic [1:0]            sl_resp;

  logic last;
  logic hs;

  assign head_sel = queue_head_data[SEL_WIDTH+LEN_WIDTH-1 -: SEL_WIDTH];
  assign head_len = queue_head_data[LEN_WIDTH-1:0];
  assign head_ok  = 32'(head_sel) < NUM_SLAVES;

  assign last = (count == len);
  assign hs   = m_r.rvalid & m_r.rready;
  assign busy = (state != IDLE);

  // Gated by rst so the pop stays low while reset is held.
  assign queue_dequeue = rst & (state == IDLE) & ~queue_empty;

  // Compare-based select keeps out-of-range codes from indexing.
  always_comb begin
    sl_hot   = '0;
    sl_valid = 1'b0;
    sl_last  = 1'b0;
    sl_data  = '0;
    sl_id    = '0;
    sl_resp  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel == SEL_WIDTH'(i)) begin
        sl_hot[i] = 1'b1;
        sl_valid  = s_rvalid[i];
        sl_last   = s_rlast[i];
        sl_data   = s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
        sl_id     = s_rid[i*ID_WIDTH +: ID_WIDTH];
        sl_resp   = s_rresp[i*2 +: 2];
      end
    end
  end

  always_comb begin
    m_r.rvalid = 1'b0;
    m_r.rdata  = '0;
    m_r.rid    = '0;
    m_r.rresp  = '0;
    m_r.rlast  = 1'b0;
    s_rready   = '0;
    unique case (state)
      ROUTE: begin
        m_r.rvalid = sl_valid;
        m_r.rdata  = sl_data;
        m_r.rid    = sl_id;
        m_r.rresp  = sl_resp;
        m_r.rlast  = last;
        s_rready   = sl_hot & {NUM_SLAVES{m_r.rready}};
      end
      DECERR: begin
        m_r.rvalid = 1'b1;
        m_r.rresp  = 2'b11;
        m_r.rlast  = last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sel       <= '0;
      len       <= '0;
      count     <= '0;
      len_error <= 1'b0;
    end else begin
      len_error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!queue_empty) begin
            sel   <= head_sel;
            len   <= head_len;
            count <= '0;
            state <= head_ok ? ROUTE : DECERR;
          end
        end
        ROUTE, DECERR: begin
          if (hs) begin
            count <= count + 1'b1;
            if (state == ROUTE && sl_last != last)
              len_error <= 1'b1;
            if (last)
              state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_r_return_router.sv
// Randomized bench for axi_r_return_router with a transaction-level
// model: queued bursts expand into expected master beats in order.
module tb_axi_r_return_router;
  localparam int NS = 3;
  localparam int SW = 2;
  localparam int LW = 8;
  localparam int IW = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [SW+LW-1:0] queue_head_data;
  logic             queue_empty;
  logic             queue_dequeue;
  logic [NS-1:0]    s_rvalid, s_rready, s_rlast;
  logic [NS*DW-1:0] s_rdata;
  logic [NS*IW-1:0] s_rid;
  logic [NS*2-1:0]  s_rresp;
  logic             busy, len_error;

  axi_r_return_router_if #(.ID_WIDTH(IW), .DATA_WIDTH(DW)) m_r ();

  axi_r_return_router #(
    .NUM_SLAVES(NS), .SEL_WIDTH(SW), .LEN_WIDTH(LW),
    .ID_WIDTH(IW), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst),
    .queue_head_data(queue_head_data),
    .queue_empty(queue_empty),
    .queue_dequeue(queue_dequeue),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_rdata(s_rdata), .s_rid(s_rid),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .m_r(m_r),
    .busy(busy), .len_error(len_error)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
    logic [1:0]    resp;
    logic          last;
    logic          slast;
    logic          lerr;
  } beat_t;

  typedef struct packed {
    logic [SW-1:0] sel;
    logic [LW-1:0] len;
  } ent_t;

  ent_t  q[$];
  beat_t exp_q[$];
  beat_t sq[NS][$];

  int n_vec = 0;
  int n_err = 0;

  logic          active = 1'b0;
  logic [SW-1:0] cur_sel = '0;
  int            remaining = 0;
  logic          lerr_pend = 1'b0;
  logic [NS-1:0] sv = '0;
  bit            fast_rdy = 1'b1;
  bit            fast_sv = 1'b1;
  logic          pstall = 1'b0;
  logic [39:0]   ppay = '0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] cur_pay();
    return {m_r.rvalid, m_r.rdata, m_r.rid, m_r.rresp, m_r.rlast};
  endfunction

  task automatic enqueue(int sel, int len, int bad);
    ent_t  e;
    beat_t b;
    e.sel = SW'(sel);
    e.len = LW'(len);
    q.push_back(e);
    for (int k = 0; k <= len; k++) begin
      b = '0;
      b.last = (k == len);
      if (sel < NS) begin
        b.data  = $urandom;
        b.id    = IW'($urandom);
        b.resp  = 2'($urandom);
        b.lerr  = (k == bad);
        b.slast = b.last ^ b.lerr;
        sq[sel].push_back(b);
      end else begin
        b.resp = 2'b11;
      end
      exp_q.push_back(b);
    end
  endtask

  task automatic drive();
    beat_t b;
    m_r.rready = fast_rdy ? 1'b1 : ($urandom_range(2) != 0);
    for (int i = 0; i < NS; i++) begin
      if (!sv[i])
        sv[i] = (sq[i].size() > 0) && (fast_sv || $urandom_range(3) != 0);
      b = (sq[i].size() > 0) ? sq[i][0] : '0;
      s_rdata[i*DW +: DW] = b.data;
      s_rid[i*IW +: IW]   = b.id;
      s_rresp[i*2 +: 2]   = b.resp;
      s_rlast[i]          = b.slast;
    end
    s_rvalid = sv;
    queue_empty = (q.size() == 0);
    queue_head_data = (q.size() > 0) ? {q[0].sel, q[0].len} : '0;
  endtask

  task automatic sample();
    logic          ev;
    logic          was_active;
    logic [NS-1:0] err;
    beat_t         b;
    ent_t          e;
    was_active = active;
    ev  = active;
    err = '0;
    for (int i = 0; i < NS; i++) begin
      if (active && int'(cur_sel) == i) begin
        ev     = s_rvalid[i];
        err[i] = m_r.rready;
      end
    end
    chk("m_rvalid", m_r.rvalid, ev);
    chk("s_rready", s_rready, err);
    chk("queue_dequeue", queue_dequeue, !active && q.size() > 0);
    chk("busy", busy, active);
    chk("len_error", len_error, lerr_pend);
    if (!active)
      chk("idle_payload", cur_pay(), 0);
    if (pstall)
      chk("stall_stable", cur_pay(), ppay);
    if (active && m_r.rvalid) begin
      n_vec++;
      assert (exp_q.size() > 0) else begin
        n_err++;
        $error("FAIL beat_unexpected: observed beat expected none");
      end
      if (exp_q.size() > 0) begin
        b = exp_q[0];
        chk("payload",
            {m_r.rdata, m_r.rid, m_r.rresp, m_r.rlast},
            {b.data, b.id, b.resp, b.last});
      end
    end
    pstall = m_r.rvalid && !m_r.rready;
    ppay = cur_pay();
    lerr_pend = 1'b0;
    if (active && m_r.rvalid && m_r.rready && exp_q.size() > 0) begin
      b = exp_q.pop_front();
      lerr_pend = b.lerr;
      remaining--;
      if (remaining == 0) active = 1'b0;
    end
    for (int i = 0; i < NS; i++) begin
      if (s_rvalid[i] && s_rready[i]) begin
        if (sq[i].size() > 0) void'(sq[i].pop_front());
        sv[i] = 1'b0;
      end
    end
    if (!was_active && q.size() > 0) begin
      e = q.pop_front();
      active = 1'b1;
      cur_sel = e.sel;
      remaining = int'(e.len) + 1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    drive();
    #3;
    sample();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() > 0 || active || exp_q.size() > 0) && n < 6000) begin
      cycle();
      n++;
    end
    n_vec++;
    assert (n < 6000) else begin
      n_err++;
      $error("FAIL drain_timeout: observed %0d cycles expected < 6000", n);
    end
    cycle();
    cycle();
  endtask

  task automatic clear_model();
    q.delete();
    exp_q.delete();
    for (int i = 0; i < NS; i++) sq[i].delete();
    sv = '0;
    active = 1'b0;
    remaining = 0;
    lerr_pend = 1'b0;
    pstall = 1'b0;
  endtask

  task automatic chk_reset_outs();
    chk("rst_m_rvalid", m_r.rvalid, 0);
    chk("rst_payload", cur_pay(), 0);
    chk("rst_s_rready", s_rready, 0);
    chk("rst_dequeue", queue_dequeue, 0);
    chk("rst_busy", busy, 0);
    chk("rst_len_error", len_error, 0);
  endtask

  initial begin
    drive();
    #1;
    chk_reset_outs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #3;
    sample();

    // single routed burst, rlast on final beat
    enqueue(1, 3, -1);
    drain();

    // back-to-back bursts from different slaves
    enqueue(0, 0, -1);
    enqueue(2, 1, -1);
    drain();

    // master stalls with slave always valid
    fast_rdy = 1'b0;
    enqueue(2, 1, -1);
    enqueue(2, 3, -1);
    drain();
    fast_rdy = 1'b1;

    // decode error burst
    enqueue(3, 1, -1);
    drain();

    // early rlast
    enqueue(0, 3, 1);
    drain();

    // async reset mid-burst with a queued entry pending
    enqueue(1, 5, -1);
    enqueue(2, 2, -1);
    cycle();
    cycle();
    cycle();
    #1;
    rst = 1'b0;
    #1;
    chk_reset_outs();
    clear_model();
    drive();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #3;
    sample();
    enqueue(2, 2, -1);
    drain();

    // maximum arlen: 256 beats
    enqueue(1, 255, -1);
    drain();

    // randomized traffic
    for (int t = 0; t < 80; t++) begin
      int sel, len, bad;
      fast_rdy = ($urandom_range(3) == 0);
      fast_sv  = ($urandom_range(3) == 0);
      sel = $urandom_range(3);
      len = $urandom_range(6);
      bad = ($urandom_range(3) == 0) ? $urandom_range(len) : -1;
      enqueue(sel, len, bad);
      for (int c = $urandom_range(4); c > 0; c--) cycle();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
